// File: rtl/core_alu_issue_pkg.sv
// core_alu_issue_pkg: opcodes, ALU operation codes and issue FSM states shared by the ALU issue stage.
package core_alu_issue_pkg;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [3:0] ALU_CODE_ADD  = 4'd0;
    localparam logic [3:0] ALU_CODE_SUB  = 4'd1;
    localparam logic [3:0] ALU_CODE_SLL  = 4'd2;
    localparam logic [3:0] ALU_CODE_SLT  = 4'd3;
    localparam logic [3:0] ALU_CODE_SLTU = 4'd4;
    localparam logic [3:0] ALU_CODE_XOR  = 4'd5;
    localparam logic [3:0] ALU_CODE_SRL  = 4'd6;
    localparam logic [3:0] ALU_CODE_SRA  = 4'd7;
    localparam logic [3:0] ALU_CODE_OR   = 4'd8;
    localparam logic [3:0] ALU_CODE_AND  = 4'd9;
    typedef enum logic [2:0] {
        ISS_IDLE = 3'd0,
        ISS_DEC  = 3'd1,
        ISS_EXEC = 3'd2,
        ISS_CAPT = 3'd3,
        ISS_WB   = 3'd4
    } iss_state_t;
    // alt selects SUB for f3=0 and SRA for f3=5 (instr[30])
    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_code = alt ? ALU_CODE_SUB : ALU_CODE_ADD;
            3'd1:    alu_code = ALU_CODE_SLL;
            3'd2:    alu_code = ALU_CODE_SLT;
            3'd3:    alu_code = ALU_CODE_SLTU;
            3'd4:    alu_code = ALU_CODE_XOR;
            3'd5:    alu_code = alt ? ALU_CODE_SRA : ALU_CODE_SRL;
            3'd6:    alu_code = ALU_CODE_OR;
            default: alu_code = ALU_CODE_AND;
        endcase
    endfunction
endpackage

// File: rtl/core_alu_decode.sv
// core_alu_decode: combinational RV32I OP/OP-IMM/LUI/AUIPC decode into ALU operation and operands.
module core_alu_decode
    import core_alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [3:0]  code,
    output logic [31:0] i1,
    output logic [31:0] i2,
    output logic [4:0]  rd,
    output logic        illegal
);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic        shift;
    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_u = {instr[31:12], 12'h000};
    assign shift = (f3 == 3'd1) || (f3 == 3'd5);
    assign rd    = instr[11:7];
    always_comb begin
        code    = ALU_CODE_ADD;
        i1      = rs1;
        i2      = imm_i;
        illegal = 1'b0;
        if (opc == OPC_OP) begin
            i2      = rs2;
            code    = alu_code(f3, f7[5]);
            illegal = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        end else if (opc == OPC_OPIMM) begin
            i2      = shift ? {27'd0, instr[24:20]} : imm_i;
            code    = alu_code(f3, f3 == 3'd5 && f7[5]);
            illegal = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
        end else if (opc == OPC_LUI) begin
            i1 = 32'd0;
            i2 = imm_u;
        end else if (opc == OPC_AUIPC) begin
            i1 = pc;
            i2 = imm_u;
        end else begin
            illegal = 1'b1;
        end
    end
endmodule

// File: rtl/core_alu_issue.sv
// core_alu_issue: single-in-flight issue stage feeding core_alu and returning its result
// as a valid/ready writeback packet.
module core_alu_issue
    import core_alu_issue_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ALU_CODE_W = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [31:0]           IN_INSTR,
    input  logic [XLEN-1:0]       IN_PC,
    input  logic [XLEN-1:0]       IN_RS1,
    input  logic [XLEN-1:0]       IN_RS2,
    output logic                  C_ALU,
    output logic [ALU_CODE_W-1:0] OPCODE_ALU,
    output logic [XLEN-1:0]       ALU_I1,
    output logic [XLEN-1:0]       ALU_I2,
    input  logic [XLEN-1:0]       ALU_O,
    output logic                  WB_VALID,
    input  logic                  WB_READY,
    output logic [4:0]            WB_RD,
    output logic                  WB_WE,
    output logic [XLEN-1:0]       WB_DATA,
    output logic                  WB_ILLEGAL
);
    iss_state_t  state, state_nxt;
    logic [31:0] instr_q, pc_q, rs1_q, rs2_q;
    logic [3:0]  dec_code;
    logic [31:0] dec_i1, dec_i2;
    logic [4:0]  dec_rd;
    logic        dec_illegal;

    core_alu_decode u_dec (
        .instr   (instr_q),
        .pc      (pc_q),
        .rs1     (rs1_q),
        .rs2     (rs2_q),
        .code    (dec_code),
        .i1      (dec_i1),
        .i2      (dec_i2),
        .rd      (dec_rd),
        .illegal (dec_illegal)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ISS_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        IN_READY  = state == ISS_IDLE;
        C_ALU     = state == ISS_EXEC;
        case (state)
            ISS_IDLE: state_nxt = IN_VALID ? ISS_DEC : ISS_IDLE;
            ISS_DEC:  state_nxt = dec_illegal ? ISS_WB : ISS_EXEC;
            ISS_EXEC: state_nxt = ISS_CAPT;
            ISS_CAPT: state_nxt = ISS_WB;
            ISS_WB:   state_nxt = WB_READY ? ISS_IDLE : ISS_WB;
            default:  state_nxt = ISS_IDLE;
        endcase
        if (FLUSH) state_nxt = ISS_IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr_q    <= '0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            OPCODE_ALU <= '0;
            ALU_I1     <= '0;
            ALU_I2     <= '0;
            WB_VALID   <= 1'b0;
            WB_RD      <= '0;
            WB_WE      <= 1'b0;
            WB_DATA    <= '0;
            WB_ILLEGAL <= 1'b0;
        end else begin
            if (state == ISS_IDLE && IN_VALID && !FLUSH) begin
                instr_q <= IN_INSTR;
                pc_q    <= IN_PC;
                rs1_q   <= IN_RS1;
                rs2_q   <= IN_RS2;
            end
            // writeback metadata is settled at DEC so it is already stable when WB_VALID rises
            if (state == ISS_DEC) begin
                OPCODE_ALU <= dec_code;
                ALU_I1     <= dec_i1;
                ALU_I2     <= dec_i2;
                WB_RD      <= dec_rd;
                WB_WE      <= !dec_illegal && dec_rd != 5'd0;
                WB_ILLEGAL <= dec_illegal;
                WB_DATA    <= '0;
            end
            if (state == ISS_CAPT) WB_DATA <= ALU_O;
            WB_VALID <= !FLUSH && ((state == ISS_DEC && dec_illegal) || state == ISS_CAPT ||
                                   (state == ISS_WB && !WB_READY));
        end
    end
endmodule
